// File: rtl/mem_responder_pkg.sv
// Shared constants and IO decode helpers for the memory-bus responder.
// IO addresses are matched on the low 18 address bits only.
package mem_responder_pkg;

    localparam logic [31:0] IO_BASE      = 32'h0003_0000;
    localparam logic [31:0] IO_TX_ADDR   = 32'h0003_0000;
    localparam logic [31:0] IO_STAT_ADDR = 32'h0003_0004;
    localparam logic [1:0]  IO_SEL       = 2'b11;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_OVF_BIT   = 1;

    typedef enum logic [1:0] {
        IO_REG_NONE = 2'd0,
        IO_REG_TX   = 2'd1,
        IO_REG_STAT = 2'd2
    } io_reg_e;

    function automatic logic is_io_addr(input logic [17:0] addr);
        return (addr[17:16] == IO_SEL);
    endfunction

    function automatic io_reg_e io_decode(input logic [17:0] addr);
        io_reg_e r;
        if (addr == IO_TX_ADDR[17:0]) begin
            r = IO_REG_TX;
        end else if (addr == IO_STAT_ADDR[17:0]) begin
            r = IO_REG_STAT;
        end else begin
            r = IO_REG_NONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_responder_tx_fifo.sv
// Output-byte FIFO for the TX port; a push into a full FIFO is accepted
// only when a pop frees an entry in the same cycle.
module tx_fifo
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty = (count_q == {CW{1'b0}});
    assign full  = (count_q == DEPTH_C);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Next-state pointer and occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless once the pointers are reset
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Responder for the byte-serial memory bus: on-chip RAM plus an IO window
// with a TX byte FIFO, a status register and a program-finish strobe.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int FIFO_DEPTH     = 8,
    parameter int FULL_MARGIN    = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_din,
    input  logic        mem_wr,
    output logic [7:0]  mem_dout,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        program_finish
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] MARGIN_C = CW'(FULL_MARGIN);

    logic [7:0]                ram [2**RAM_ADDR_WIDTH];
    logic [RAM_ADDR_WIDTH-1:0] ram_addr_s;
    logic                      is_io_s;
    io_reg_e                   io_reg_s;
    logic                      fifo_push_s;
    logic                      fifo_pop_s;
    logic                      fifo_empty_s;
    logic                      fifo_full_s;
    logic [CW-1:0]             fifo_count_s;
    logic [CW-1:0]             free_s;
    logic [7:0]                status_s;
    logic [7:0]                mem_dout_q, mem_dout_d;
    logic                      overflow_q, overflow_d;
    logic                      finish_q, finish_d;
    logic                      unused_addr_s;

    assign unused_addr_s = ^mem_a[31:18];

    assign ram_addr_s = mem_a[RAM_ADDR_WIDTH-1:0];
    assign is_io_s    = is_io_addr(mem_a[17:0]);
    assign io_reg_s   = io_decode(mem_a[17:0]);

    assign fifo_push_s = rdy_in && mem_wr && is_io_s && (io_reg_s == IO_REG_TX);
    assign tx_valid    = rdy_in && !fifo_empty_s;
    assign fifo_pop_s  = tx_valid && tx_ready;

    // Free entries counted before any in-flight write lands
    assign free_s         = DEPTH_C - fifo_count_s;
    assign io_buffer_full = (free_s <= MARGIN_C);

    assign mem_dout       = mem_dout_q;
    assign program_finish = finish_q;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .push  (fifo_push_s),
        .din   (mem_din),
        .pop   (fifo_pop_s),
        .dout  (tx_data),
        .empty (fifo_empty_s),
        .full  (fifo_full_s),
        .count (fifo_count_s)
    );

    // Status byte assembly
    always_comb begin
        status_s                 = 8'h00;
        status_s[STAT_OVF_BIT]   = overflow_q;
        status_s[STAT_EMPTY_BIT] = fifo_empty_s;
    end

    // Read-data, overflow and finish next-state logic
    always_comb begin
        mem_dout_d = mem_dout_q;
        overflow_d = overflow_q;
        finish_d   = 1'b0;
        if (rdy_in && !mem_wr) begin
            if (is_io_s) begin
                case (io_reg_s)
                    IO_REG_TX:   mem_dout_d = 8'h00;
                    IO_REG_STAT: mem_dout_d = status_s;
                    default:     mem_dout_d = 8'h00;
                endcase
            end else begin
                mem_dout_d = ram[ram_addr_s];
            end
        end else begin
            mem_dout_d = mem_dout_q;
        end
        // A dropped byte is only a loss when no pop frees a slot this cycle
        if (fifo_push_s && fifo_full_s && !fifo_pop_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
        if (rdy_in && mem_wr && is_io_s && (io_reg_s == IO_REG_STAT)) begin
            finish_d = 1'b1;
        end else begin
            finish_d = 1'b0;
        end
    end

    // Control and read-data registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mem_dout_q <= 8'h00;
            overflow_q <= 1'b0;
            finish_q   <= 1'b0;
        end else begin
            mem_dout_q <= mem_dout_d;
            overflow_q <= overflow_d;
            finish_q   <= finish_d;
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk_in) begin
        if (rdy_in && mem_wr && !is_io_s) begin
            ram[ram_addr_s] <= mem_din;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: read data and TX bytes are queued at
// issue time and checked by independent monitors.
module tb_mem_responder;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic [7:0]  mem_din;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        program_finish;

    logic [7:0]  rd_q[$];
    logic [7:0]  tx_q[$];
    logic        rd_track = 1'b0;
    logic        rd_pend  = 1'b0;
    int          errors   = 0;
    int          checks   = 0;

    mem_responder dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .rdy_in         (rdy_in),
        .mem_a          (mem_a),
        .mem_din        (mem_din),
        .mem_wr         (mem_wr),
        .mem_dout       (mem_dout),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .program_finish (program_finish)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        mem_a   = a;
        mem_din = d;
        mem_wr  = 1'b1;
        tick();
        mem_wr  = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] exp);
        mem_a    = a;
        mem_wr   = 1'b0;
        rd_track = 1'b1;
        rd_q.push_back(exp);
        tick();
        rd_track = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] d);
        tx_q.push_back(d);
        wr(32'h0003_0000, d);
    endtask

    task automatic drain();
        tx_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (tx_valid) tick();
        end
        chk("drain_done", {31'd0, tx_valid}, 32'd0);
        chk("txq_drained", tx_q.size(), 32'd0);
    endtask

    // Read-data and TX monitors, sampled on the falling edge
    always @(negedge clk_in) begin
        if (rd_pend) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_q_underflow: got read data %0h with nothing expected", mem_dout);
            end else begin
                chk("mem_dout", {24'd0, mem_dout}, {24'd0, rd_q.pop_front()});
            end
        end
        rd_pend = rd_track && rdy_in && rst_n_in;
        if (tx_valid && tx_ready) begin
            if (tx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_q_underflow: got tx byte %0h with nothing expected", tx_data);
            end else begin
                chk("tx_data", {24'd0, tx_data}, {24'd0, tx_q.pop_front()});
            end
        end
    end

    initial begin
        rst_n_in = 1'b0;
        rdy_in   = 1'b1;
        mem_a    = 32'h0000_0000;
        mem_din  = 8'h00;
        mem_wr   = 1'b0;
        tx_ready = 1'b0;
        repeat (3) tick();
        chk("rst_dout", {24'd0, mem_dout}, 32'd0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_full", {31'd0, io_buffer_full}, 32'd0);
        chk("rst_finish", {31'd0, program_finish}, 32'd0);
        rst_n_in = 1'b1;
        tick();

        // Single RAM write/read, hold on write, upper address bits ignored
        wr(32'h0000_0010, 8'hA5);
        rd(32'h0000_0010, 8'hA5);
        wr(32'h0000_0020, 8'h5A);
        chk("dout_hold_on_write", {24'd0, mem_dout}, 32'h0000_00A5);
        rd(32'h1234_0010, 8'hA5);
        rd(32'h0000_0020, 8'h5A);

        // Back-to-back reads
        wr(32'h0000_0100, 8'h11);
        wr(32'h0000_0101, 8'h22);
        wr(32'h0000_0102, 8'h33);
        wr(32'h0000_0103, 8'h44);
        rd(32'h0000_0100, 8'h11);
        rd(32'h0000_0101, 8'h22);
        rd(32'h0000_0102, 8'h33);
        rd(32'h0000_0103, 8'h44);

        // rdy_in low freezes RAM, FIFO and read data
        rdy_in  = 1'b0;
        mem_a   = 32'h0000_0010;
        mem_din = 8'hFF;
        mem_wr  = 1'b1;
        tick();
        chk("dout_frozen", {24'd0, mem_dout}, 32'h0000_0044);
        mem_a   = 32'h0003_0000;
        mem_din = 8'h77;
        tick();
        chk("tx_valid_frozen", {31'd0, tx_valid}, 32'd0);
        mem_wr  = 1'b0;
        rdy_in  = 1'b1;
        rd(32'h0000_0010, 8'hA5);
        rd(32'h0003_0004, 8'h01);

        // Near-full threshold on the way up and down
        for (int i = 0; i < 6; i++) begin
            push_tx(8'h41);
            if (i == 4) chk("full_at_5", {31'd0, io_buffer_full}, 32'd0);
        end
        chk("full_at_6", {31'd0, io_buffer_full}, 32'd1);
        tx_ready = 1'b1;
        tick();
        chk("full_falls_at_5", {31'd0, io_buffer_full}, 32'd0);
        drain();

        // Full FIFO with a simultaneous pop accepts the push
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_tx(8'h50 + 8'(i));
        chk("full_at_8", {31'd0, io_buffer_full}, 32'd1);
        tx_ready = 1'b1;
        push_tx(8'h58);
        tx_ready = 1'b0;
        rd(32'h0003_0004, 8'h00);
        wr(32'h0003_0000, 8'h59);
        rd(32'h0003_0004, 8'h02);
        rd(32'h0003_0000, 8'h00);
        drain();
        rd(32'h0003_0004, 8'h03);

        // Finish strobe and ignored IO offset
        wr(32'h0003_0004, 8'hFF);
        chk("finish_pulse", {31'd0, program_finish}, 32'd1);
        tick();
        chk("finish_one_cycle", {31'd0, program_finish}, 32'd0);
        wr(32'h0003_0008, 8'h12);
        chk("no_finish_other", {31'd0, program_finish}, 32'd0);
        rd(32'h0003_0004, 8'h03);

        // Reset during a drain with a finish pulse pending
        tx_ready = 1'b0;
        push_tx(8'h61);
        push_tx(8'h62);
        push_tx(8'h63);
        tx_ready = 1'b1;
        tick();
        wr(32'h0003_0004, 8'h00);
        rst_n_in = 1'b0;
        tx_q.delete();
        #1;
        chk("rst_mid_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_mid_finish", {31'd0, program_finish}, 32'd0);
        chk("rst_mid_full", {31'd0, io_buffer_full}, 32'd0);
        chk("rst_mid_dout", {24'd0, mem_dout}, 32'd0);
        tick();
        rst_n_in = 1'b1;
        tx_ready = 1'b0;
        tick();
        rd(32'h0003_0004, 8'h01);
        rd(32'h0000_0103, 8'h44);

        repeat (2) tick();
        chk("rdq_empty", rd_q.size(), 32'd0);
        chk("txq_empty", tx_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Responder end of the byte-serial memory bus driven by the CPU's memory controller: one address and one byte per cycle, read data returned one cycle later.
- Decodes each access to either a byte-addressed on-chip RAM or an IO window.
- The IO window holds an output-byte FIFO drained over a valid/ready TX port, a status register, and a program-finish strobe.
- Drives the io_buffer_full back-pressure signal consumed by the controller.

Parameters:
- RAM_ADDR_WIDTH, 17, RAM size is 2^RAM_ADDR_WIDTH bytes.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, ≥ 4.
- FULL_MARGIN, 2, io_buffer_full asserts when free entries ≤ FULL_MARGIN.

Ports:
- clk_in  in  1  clock; all logic on rising edge.
- rst_n_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  global enable; low freezes all state.
- mem_a  in  32  byte address from controller.
- mem_din  in  8  write byte from controller.
- mem_wr  in  1  1 = write, 0 = read.
- mem_dout  out  8  read byte, registered.
- io_buffer_full  out  1  TX FIFO near-full.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO non-empty and rdy_in high.
- tx_ready  in  1  consumer accepts the head byte this cycle.
- program_finish  out  1  one-cycle pulse on a write to the finish address.

Behaviour:
- Reset (async, rst_n_in = 0): mem_dout = 0, FIFO empty (head = tail = count = 0), overflow = 0, program_finish = 0. RAM contents are not reset.
- Decode: mem_a[17:16] == 2'b11 selects IO; otherwise RAM at mem_a[RAM_ADDR_WIDTH-1:0]. Upper address bits are ignored.
- rdy_in = 0: no RAM write, no FIFO push or pop, mem_dout holds, tx_valid = 0, program_finish = 0.
- RAM read (mem_wr = 0): mem_dout <= ram[a] at the edge; the value is visible the cycle after the address. Back-to-back reads give one byte per cycle.
- RAM write (mem_wr = 1): ram[a] <= mem_din at the edge; mem_dout holds its previous value.
- IO write 0x30000: push mem_din into the FIFO.
  - Full with no pop this cycle: drop the byte and set overflow (sticky until reset).
  - Full with a pop this cycle: push is accepted.
- IO write 0x30004: program_finish = 1 for exactly the next cycle; data ignored.
- IO writes to other offsets: ignored.
- IO read 0x30000: mem_dout <= 0x00.
- IO read 0x30004: mem_dout <= {6'b0, overflow, fifo_empty}.
- IO reads have no side effects and the same 1-cycle latency as RAM reads.
- TX handshake:
  - tx_data = FIFO head (combinational).
  - Pop on tx_valid && tx_ready.
  - tx_data stays stable while tx_valid is high and tx_ready is low.
- Count arithmetic: push only → +1, pop only → −1, both → unchanged. Pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.
- io_buffer_full = (FIFO_DEPTH − count) ≤ FULL_MARGIN, combinational from count. This leaves headroom for a write already issued by the controller.
- Reset mid-operation: FIFO contents are discarded; a pending finish pulse is cancelled.

Decomposition:
- Shared package: IO_BASE = 0x30000, IO_TX_ADDR = 0x30000, IO_STAT_ADDR = 0x30004, decode constant 2'b11, status bit positions.
- One sub-module: tx_fifo.
  - Parameters: DEPTH, WIDTH = 8.
  - Ports: push, din, pop, dout, empty, full, count.
- RAM is an inferred array inside mem_responder.

Test Plan:
- Write 0xA5 to RAM 0x00010, then read 0x00010 → mem_dout = 0xA5 exactly one cycle after the read address.
- Write 0x11, 0x22, 0x33, 0x44 to 0x100..0x103, then read 0x100..0x103 on consecutive cycles → mem_dout sequence 0x11, 0x22, 0x33, 0x44, each one cycle late.
- With tx_ready = 0, write 0x41 to 0x30000 six times (FIFO_DEPTH = 8) → io_buffer_full rises after the 6th push. Then tx_ready = 1 → bytes 0x41 drain one per cycle and io_buffer_full falls when count drops to 5.
- Push 9 bytes with tx_ready = 0 → 9th byte dropped; read 0x30004 → 0x02 (overflow = 1, empty = 0).
- FIFO full with tx_ready = 1 and a push in the same cycle → count stays 8, no overflow.
- Write to 0x30004 → program_finish high for one cycle. Assert rst_n_in mid-drain → FIFO empty, tx_valid = 0 immediately; read 0x30004 → 0x01.
